// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Size encoding, FSM states, alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    CAPTURE = 2'b10,
    WRITE   = 2'b11
  } lsu_state_t;

  function automatic logic bad_req(
    input lsu_size_t  size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_format.sv
// Load extraction/extension and sub-word
// store merge; purely combinational.
module lsu_format
  import lsu_pkg::*;
(
  input  lsu_size_t   size,
  input  logic        zero_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic sb;
  logic sh;

  assign sb = ~zero_ext & rdata[7];
  assign sh = ~zero_ext & rdata[15];

  // Extend the low lane and splice store data.
  always_comb begin
    load_data  = rdata;
    merge_data = wdata;
    unique case (size)
      SZ_BYTE: begin
        load_data  = {{24{sb}}, rdata[7:0]};
        merge_data = {rdata[31:8], wdata[7:0]};
      end
      SZ_HALF: begin
        load_data  = {{16{sh}}, rdata[15:0]};
        merge_data = {rdata[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access with
// read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t state;
  lsu_state_t next;
  lsu_size_t  op_size;
  logic       op_write;
  logic       op_uns;
  logic       accept;
  logic       bad;
  logic       direct;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign accept = req_valid && req_ready;
  assign bad    = bad_req(lsu_size_t'(req_size),
                          req_addr[1:0]);
  assign direct = req_write &&
                  (req_size == SZ_WORD);

  lsu_format u_format (
    .size       (op_size),
    .zero_ext   (op_uns),
    .rdata      (mem_rdata),
    .wdata      (mem_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    next      = state;
    req_ready = 1'b0;
    mem_wr_en = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept && !bad)
          next = direct ? WRITE : READ;
      end
      READ:    next = CAPTURE;
      CAPTURE: next = op_write ? WRITE : IDLE;
      WRITE: begin
        mem_wr_en = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Request latch, memory drive and response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_size    <= SZ_BYTE;
      op_write   <= 1'b0;
      op_uns     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_size   <= lsu_size_t'(req_size);
            op_write  <= req_write;
            op_uns    <= req_unsigned;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            if (bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (op_write) begin
            mem_wdata <= merge_data;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        WRITE:   resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a
// byte-addressed model memory.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr_en    (mem_wr_en),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [256];
  int          cyc = 0;
  int          wr_cnt = 0;
  int          total = 0;
  int          passed = 0;
  int          last_due = 0;
  bit          chk_b2b = 0;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h",
                  name, act, want);
  endtask

  function automatic logic [31:0] mword(
    input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)],
            mem[8'(a + 8'd1)], mem[a]};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock)
    mem_rdata <= mword(mem_addr[7:0]);

  always @(negedge clock) begin
    if (mem_wr_en) begin
      wr_cnt++;
      for (int k = 0; k < 4; k++)
        mem[8'(mem_addr[7:0] + 8'(k))] =
          mem_wdata[8*k +: 8];
    end
  end

  // Monitor: pop and compare each response.
  always @(negedge clock) begin
    if (reset_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err},
              {31'd0, e.err});
        check("latency", cyc, e.due);
      end
    end
  end

  // Call at a negedge; returns at the negedge
  // after acceptance. lat < 0: no response.
  task automatic issue(logic wr, logic [1:0] sz,
                       logic uns, logic [31:0] a,
                       logic [31:0] wd,
                       logic [31:0] rd, logic er,
                       int lat);
    int n;
    exp_t e;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      if (chk_b2b)
        check("b2b_accept", cyc, last_due);
      if (lat >= 0) begin
        e.rdata = rd;
        e.err   = er;
        e.due   = cyc + 1 + lat;
        last_due = e.due;
        exp_q.push_back(e);
      end
      @(negedge clock);
    end
  endtask

  task automatic idle(int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int wr0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h11] = 8'h44; mem[8'h12] = 8'h33;
    mem[8'h13] = 8'h22; mem[8'h14] = 8'h11;
    mem[8'h20] = 8'h80;
    mem[8'h30] = 8'h01; mem[8'h31] = 8'h80;
    mem[8'h40] = 8'h77;

    repeat (3) @(negedge clock);
    check("rst_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_resp_err", {31'd0, resp_err}, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", {31'd0, req_ready}, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Byte store over 0x11223344 at 0x11 (RMW).
    issue(1, 2'b00, 0, 32'h11, 32'hA5, 0, 0, 3);
    idle(5);
    check("rmw_word", mword(8'h11), 32'h112233A5);
    check("rmw_wr_cnt", wr_cnt, 1);
    issue(0, 2'b00, 1, 32'h11, 0, 32'hA5, 0, 2);
    issue(0, 2'b01, 0, 32'h12, 0,
          32'h00002233, 0, 2);
    idle(4);

    // Word store then word load.
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF,
          0, 0, 1);
    idle(3);
    check("wstore_wr_cnt", wr_cnt, 2);
    issue(0, 2'b10, 0, 32'h10, 0,
          32'hDEADBEEF, 0, 2);
    idle(4);

    // Sign/zero extension.
    issue(0, 2'b00, 0, 32'h20, 0,
          32'hFFFFFF80, 0, 2);
    issue(0, 2'b00, 1, 32'h20, 0,
          32'h00000080, 0, 2);
    issue(0, 2'b01, 0, 32'h30, 0,
          32'hFFFF8001, 0, 2);
    idle(4);

    // Errors: no memory writes.
    wr0 = wr_cnt;
    issue(0, 2'b01, 0, 32'h13, 0, 0, 1, 0);
    issue(1, 2'b10, 0, 32'h12, 32'h1, 0, 1, 0);
    issue(1, 2'b11, 0, 32'h20, 32'h2, 0, 1, 0);
    idle(4);
    check("err_wr_cnt", wr_cnt, wr0);
    check("err_mem", mword(8'h10), 32'hDEADBEEF);

    // Reset during CAPTURE of a byte store.
    wr0 = wr_cnt;
    issue(1, 2'b00, 0, 32'h40, 32'h5A, 0, 0, -1);
    req_valid = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("abort_ready", {31'd0, req_ready}, 1);
    idle(5);
    check("abort_wr_cnt", wr_cnt, wr0);
    check("abort_mem", {24'd0, mem[8'h40]}, 32'h77);

    // Back-to-back with req_valid held.
    issue(0, 2'b10, 0, 32'h10, 0,
          32'hDEADBEEF, 0, 2);
    chk_b2b = 1;
    issue(0, 2'b00, 0, 32'h20, 0,
          32'hFFFFFF80, 0, 2);
    issue(1, 2'b10, 0, 32'h50, 32'hCAFEF00D,
          0, 0, 1);
    issue(1, 2'b01, 0, 32'h52, 32'h1234, 0, 0, 3);
    issue(1, 2'b11, 0, 32'h50, 0, 0, 1, 0);
    issue(0, 2'b00, 1, 32'h53, 0, 32'h12, 0, 2);
    issue(0, 2'b10, 0, 32'h50, 0,
          32'h1234F00D, 0, 2);
    chk_b2b = 0;
    idle(1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("drain", exp_q.size(), 0);
    check("final_mem", mword(8'h52), 32'h00001234);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
